// File: rtl/fb_fifo_pkg.sv
// Shared helpers for the framebuffer pixel FIFO: log2 sizing and
// elaboration-time legality check of the parameter set.
package fb_fifo_pkg;

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((64'(1) << res) < 64'(value)) res++;
      return res;
   endfunction

   // Sizing for the default 16-entry configuration.
   localparam int unsigned DEPTH_DEF = 16;
   localparam int unsigned ADDR_W    = clog2(DEPTH_DEF);
   localparam int unsigned PTR_W     = ADDR_W + 1;

   // True when the parameter set describes a buildable FIFO.
   function automatic bit params_ok(input int unsigned data_w,
                                    input int unsigned depth,
                                    input int unsigned af_thresh,
                                    input int unsigned ae_thresh);
      bit ok;
      ok = (data_w >= 1) && (data_w <= 256);
      ok = ok && (depth >= 4) && (depth <= 1024);
      ok = ok && ((depth & (depth - 1)) == 0);
      ok = ok && (af_thresh >= 1) && (af_thresh <= depth);
      ok = ok && (ae_thresh < depth);
      return ok;
   endfunction

endpackage

// File: rtl/fb_fifo_if.sv
// Avalon-style write/read handshake between the pixel producer, the FIFO
// and the scan-out reader.
//   master: drives in_writedata/in_write/out_read
//   slave : drives in_waitrequest/out_readdata/out_waitrequest
interface fb_fifo_if #(
   parameter int unsigned DATA_W = 64
);
   logic [DATA_W-1:0] in_writedata;
   logic              in_write;
   logic              in_waitrequest;
   logic [DATA_W-1:0] out_readdata;
   logic              out_read;
   logic              out_waitrequest;

   modport master (
      output in_writedata, in_write, out_read,
      input  in_waitrequest, out_readdata, out_waitrequest
   );

   modport slave (
      input  in_writedata, in_write, out_read,
      output in_waitrequest, out_readdata, out_waitrequest
   );
endinterface

// File: rtl/fb_fifo_ram.sv
// Simple dual-port storage for the FIFO: registered write, asynchronous read.
//   clk          : write clock
//   we/waddr/wdata : write port
//   raddr/rdata  : combinational read port
module fb_fifo_ram
   import fb_fifo_pkg::*;
#(
   parameter  int unsigned DATA_W    = 64,
   parameter  int unsigned DEPTH     = 16,
   localparam int unsigned ADDR_BITS = clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [DATA_W-1:0]    wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [DATA_W-1:0]    rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // No reset: contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fb_fifo_param.sv
// Parametrised framebuffer pixel FIFO with show-ahead read data.
//   clk_clk, reset_reset_n : clock, async active-low reset
//   bus (slave)            : write port with in_waitrequest, read port with
//                            out_waitrequest; out_readdata is the head word
//   flush                  : synchronous clear, overrides reads and writes
//   level                  : occupancy 0..DEPTH
//   almost_full/empty      : level threshold flags
//   err                    : sticky pop-while-empty, cleared by flush/reset
module fb_fifo_param
   import fb_fifo_pkg::*;
#(
   parameter  int unsigned DATA_W    = 64,
   parameter  int unsigned DEPTH     = 16,
   parameter  int unsigned AF_THRESH = 12,
   parameter  int unsigned AE_THRESH = 4,
   localparam int unsigned ADDR_BITS = clog2(DEPTH),
   localparam int unsigned PTR_BITS  = ADDR_BITS + 1
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   fb_fifo_if.slave            bus,
   input  logic                flush,
   output logic [PTR_BITS-1:0] level,
   output logic                almost_full,
   output logic                almost_empty,
   output logic                err
);

   if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
      $error("fb_fifo_param: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH");
   end

   logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS-1:0] level_q, level_d;
   logic                full_q, full_d;
   logic                empty_q, empty_d;
   logic                af_q, af_d;
   logic                ae_q, ae_d;
   logic                err_q, err_d;
   logic                wr_acc;
   logic                rd_acc;

   // Handshake acceptance; flush blocks both sides.
   assign wr_acc = bus.in_write && !full_q && !flush;
   assign rd_acc = bus.out_read && !empty_q && !flush;

   // Next pointers, occupancy and flags.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         err_d    = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
         if (bus.out_read && empty_q) err_d = 1'b1;
      end
      level_d = wr_ptr_d - rd_ptr_d;
      empty_d = (wr_ptr_d == rd_ptr_d);
      // Same slot but different lap: the writer is a full turn ahead.
      full_d  = (wr_ptr_d[ADDR_BITS-1:0] == rd_ptr_d[ADDR_BITS-1:0]) &&
                (wr_ptr_d[ADDR_BITS] != rd_ptr_d[ADDR_BITS]);
      af_d    = (level_d >= PTR_BITS'(AF_THRESH));
      ae_d    = (level_d <= PTR_BITS'(AE_THRESH));
   end

   // Control state register.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         err_q    <= err_d;
      end
   end

   fb_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk_clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q[ADDR_BITS-1:0]),
      .wdata (bus.in_writedata),
      .raddr (rd_ptr_q[ADDR_BITS-1:0]),
      .rdata (bus.out_readdata)
   );

   assign bus.in_waitrequest  = full_q | flush;
   assign bus.out_waitrequest = empty_q | flush;
   assign level               = level_q;
   assign almost_full         = af_q;
   assign almost_empty        = ae_q;
   assign err                 = err_q;

endmodule

// File: tb/tb_fb_fifo_param.sv
// Bench for fb_fifo_param: directed sequences on a 64x16 instance and
// randomized traffic on a 32x64 instance, both checked every cycle against a
// queue-based reference model.
module tb_fb_fifo_param;

   logic clk;
   logic rst_a, rst_b;
   logic fl_a, fl_b;
   logic [4:0] lvl_a;
   logic [6:0] lvl_b;
   logic af_a, ae_a, err_a;
   logic af_b, ae_b, err_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: one queue and sticky error per instance.
   logic [63:0] mq [2][$];
   logic        merr [2];

   fb_fifo_if #(.DATA_W(64)) ia ();
   fb_fifo_if #(.DATA_W(32)) ib ();

   fb_fifo_param #(
      .DATA_W(64), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4)
   ) dut_a (
      .clk_clk       (clk),
      .reset_reset_n (rst_a),
      .bus           (ia),
      .flush         (fl_a),
      .level         (lvl_a),
      .almost_full   (af_a),
      .almost_empty  (ae_a),
      .err           (err_a)
   );

   fb_fifo_param #(
      .DATA_W(32), .DEPTH(64), .AF_THRESH(60), .AE_THRESH(2)
   ) dut_b (
      .clk_clk       (clk),
      .reset_reset_n (rst_b),
      .bus           (ib),
      .flush         (fl_b),
      .level         (lvl_b),
      .almost_full   (af_b),
      .almost_empty  (ae_b),
      .err           (err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   // One cycle of the reference model: compare outputs against the model
   // state, then apply this cycle's requests to the model.
   task automatic step(input int id, input int dep, input int afth, input int aeth,
                       input logic rstn, input logic wr, input logic rd, input logic fl,
                       input logic [63:0] wd, input logic iw, input logic ow,
                       input logic [63:0] rdat, input int lv,
                       input logic afv, input logic aev, input logic erv);
      string p;
      int    sz;
      logic  ow_exp;
      p = (id == 0) ? "a" : "b";
      if (!rstn) begin
         mq[id].delete();
         merr[id] = 1'b0;
      end
      sz     = mq[id].size();
      ow_exp = (sz == 0) || fl;
      chk({p, ".in_waitrequest"}, 64'(iw), 64'((sz == dep) || fl));
      chk({p, ".out_waitrequest"}, 64'(ow), 64'(ow_exp));
      chk({p, ".level"}, 64'(lv), 64'(sz));
      chk({p, ".almost_full"}, 64'(afv), 64'(sz >= afth));
      chk({p, ".almost_empty"}, 64'(aev), 64'(sz <= aeth));
      chk({p, ".err"}, 64'(erv), 64'(merr[id]));
      if (!ow_exp) chk({p, ".readdata"}, rdat, mq[id][0]);
      if (rstn) begin
         if (fl) begin
            mq[id].delete();
            merr[id] = 1'b0;
         end else begin
            if (rd) begin
               if (sz > 0) void'(mq[id].pop_front());
               else merr[id] = 1'b1;
            end
            if (wr && sz < dep) mq[id].push_back(wd);
         end
      end
   endtask

   // Monitor: mid-cycle, inputs and outputs are both stable.
   always @(negedge clk) begin
      step(0, 16, 12, 4, rst_a, ia.in_write, ia.out_read, fl_a, ia.in_writedata,
           ia.in_waitrequest, ia.out_waitrequest, ia.out_readdata, int'(lvl_a),
           af_a, ae_a, err_a);
      step(1, 64, 60, 2, rst_b, ib.in_write, ib.out_read, fl_b, 64'(ib.in_writedata),
           ib.in_waitrequest, ib.out_waitrequest, 64'(ib.out_readdata), int'(lvl_b),
           af_b, ae_b, err_b);
   end

   // Present one cycle of requests to instance a, then return to idle.
   task automatic drv_a(input logic wr, input logic [63:0] d, input logic rd, input logic fl);
      ia.in_write     = wr;
      ia.in_writedata = d;
      ia.out_read     = rd;
      fl_a            = fl;
      @(posedge clk);
      #1;
      ia.in_write = 1'b0;
      ia.out_read = 1'b0;
      fl_a        = 1'b0;
   endtask

   initial begin
      int unsigned wp, rp;
      merr[0] = 1'b0;
      merr[1] = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0;
      fl_a = 1'b0;  fl_b = 1'b0;
      ia.in_write = 1'b0; ia.out_read = 1'b0; ia.in_writedata = '0;
      ib.in_write = 1'b0; ib.out_read = 1'b0; ib.in_writedata = '0;
      wp = 50; rp = 50;

      // Reset values.
      #12;
      chk("a.rst_level", 64'(lvl_a), 64'd0);
      chk("a.rst_out_wait", 64'(ia.out_waitrequest), 64'd1);
      chk("a.rst_in_wait", 64'(ia.in_waitrequest), 64'd0);
      chk("a.rst_almost_empty", 64'(ae_a), 64'd1);
      chk("a.rst_err", 64'(err_a), 64'd0);
      @(posedge clk); #1;
      rst_a = 1'b1; rst_b = 1'b1;
      drv_a(1'b0, 64'd0, 1'b0, 1'b0);

      // Two words: one-cycle fall-through, then drain.
      drv_a(1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
      chk("a.first_visible", ia.out_readdata, 64'h1111_1111_1111_1111);
      chk("a.first_valid", 64'(ia.out_waitrequest), 64'd0);
      drv_a(1'b1, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
      drv_a(1'b0, 64'd0, 1'b1, 1'b0);
      chk("a.second_visible", ia.out_readdata, 64'h2222_2222_2222_2222);
      drv_a(1'b0, 64'd0, 1'b1, 1'b0);
      chk("a.drained_wait", 64'(ia.out_waitrequest), 64'd1);
      chk("a.drained_level", 64'(lvl_a), 64'd0);

      // Fill to DEPTH, hold a 17th write, pop while full.
      for (int i = 0; i < 16; i++) drv_a(1'b1, 64'(i), 1'b0, 1'b0);
      chk("a.full_level", 64'(lvl_a), 64'd16);
      chk("a.full_in_wait", 64'(ia.in_waitrequest), 64'd1);
      chk("a.full_almost_full", 64'(af_a), 64'd1);
      drv_a(1'b1, 64'd16, 1'b0, 1'b0);
      drv_a(1'b1, 64'd16, 1'b0, 1'b0);
      chk("a.held_level", 64'(lvl_a), 64'd16);
      drv_a(1'b1, 64'd16, 1'b1, 1'b0);
      chk("a.pop_at_full_level", 64'(lvl_a), 64'd15);
      chk("a.pop_at_full_head", ia.out_readdata, 64'd1);
      drv_a(1'b1, 64'd16, 1'b0, 1'b0);
      chk("a.refill_level", 64'(lvl_a), 64'd16);
      for (int i = 0; i < 16; i++) drv_a(1'b0, 64'd0, 1'b1, 1'b0);
      chk("a.empty_again", 64'(lvl_a), 64'd0);

      // Pop while empty sets a sticky error; flush clears it and drops a write.
      drv_a(1'b0, 64'd0, 1'b1, 1'b0);
      chk("a.err_set", 64'(err_a), 64'd1);
      drv_a(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
      drv_a(1'b0, 64'd0, 1'b1, 1'b0);
      chk("a.err_sticky", 64'(err_a), 64'd1);
      drv_a(1'b1, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b1);
      chk("a.flush_level", 64'(lvl_a), 64'd0);
      chk("a.flush_err", 64'(err_a), 64'd0);
      chk("a.flush_out_wait", 64'(ia.out_waitrequest), 64'd1);
      drv_a(1'b0, 64'd0, 1'b0, 1'b0);
      drv_a(1'b0, 64'd0, 1'b0, 1'b0);
      chk("a.flush_discarded", 64'(lvl_a), 64'd0);

      // Randomized traffic on instance b, with an async reset mid-burst.
      for (int c = 0; c < 10000; c++) begin
         if (c % 500 == 0) begin
            wp = $urandom_range(10, 95);
            rp = $urandom_range(10, 95);
         end
         ib.in_write     = ($urandom_range(0, 99) < wp);
         ib.in_writedata = $urandom;
         ib.out_read     = ($urandom_range(0, 99) < rp);
         fl_b            = ($urandom_range(0, 299) == 0);
         rst_b           = !(c == 5000 || c == 5001);
         @(posedge clk);
         #1;
      end
      ib.in_write = 1'b0; ib.out_read = 1'b0; fl_b = 1'b0; rst_b = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
